rotor_reverse: RTL and testbench

- Return-path (reflector-to-keyboard) stage for one Rotor I position.
- Applies the inverse of wiring EKMFLGDQVZNTOWYHXUSPAIBRCJ, with rotor position and ring-setting offsets.
- Owns the rotor's stepping position counter and generates the turnover carry for the next rotor.
- 2-stage pipeline with valid/ready handshakes on input and output.

---
 rtl/enigma_pkg.sv | 39 +++
 rtl/rotor_inv_lut.sv | 17 +
 rtl/rotor_reverse.sv | 116 +++++++++++
 tb/tb_rotor_reverse.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// enigma_pkg: constants, types and helpers shared by the Enigma rotor stages.
//   ALPHA          - alphabet size (letters 0..25)
//   INVALID_LETTER - code emitted for an out-of-range input letter
//   letter_t       - 5-bit letter code
//   ROTOR_I        - forward wiring of Rotor I (EKMFLGDQVZNTOWYHXUSPAIBRCJ)
//   ROTOR_I_INV    - inverse of ROTOR_I, used on the reflector-to-keyboard path
//   mod26_add      - (a + b - c) mod 26 without any unsigned subtraction
package enigma_pkg;

    localparam int ALPHA          = 26;
    localparam int INVALID_LETTER = 31;

    typedef logic [4:0] letter_t;

    localparam letter_t ROTOR_I [ALPHA] = '{
        5'd4,  5'd10, 5'd12, 5'd5,  5'd11, 5'd6,  5'd3,  5'd16, 5'd21,
        5'd25, 5'd13, 5'd19, 5'd14, 5'd22, 5'd24, 5'd7,  5'd23, 5'd20,
        5'd18, 5'd15, 5'd0,  5'd8,  5'd1,  5'd17, 5'd2,  5'd9
    };

    localparam letter_t ROTOR_I_INV [ALPHA] = '{
        5'd20, 5'd22, 5'd24, 5'd6,  5'd0,  5'd3,  5'd5,  5'd15, 5'd21,
        5'd25, 5'd1,  5'd4,  5'd2,  5'd10, 5'd12, 5'd19, 5'd7,  5'd23,
        5'd18, 5'd11, 5'd17, 5'd8,  5'd13, 5'd16, 5'd14, 5'd9
    };

    // (a + b - c) mod 26 for a, b, c in 0..25.
    // Subtraction is folded in as + (26 - c), so the 7-bit sum stays in
    // 1..76 and two conditional subtractions of 26 bring it into 0..25.
    function automatic letter_t mod26_add(input letter_t a, input letter_t b,
                                          input letter_t c);
        logic [6:0] s;
        s = {2'b00, a} + {2'b00, b} + (7'd26 - {2'b00, c});
        if (s >= 7'd26) s = s - 7'd26;
        if (s >= 7'd26) s = s - 7'd26;
        return s[4:0];
    endfunction

endpackage

// File: rtl/rotor_inv_lut.sv
// rotor_inv_lut: combinational inverse Rotor I wiring lookup.
//   letter  in   5  wiring contact index (0..25)
//   mapped  out  5  inverse-wired contact, or 31 for an index >= 26
module rotor_inv_lut (
    input  logic [4:0] letter,
    output logic [4:0] mapped
);
    import enigma_pkg::*;

    always_comb begin
        mapped = letter_t'(INVALID_LETTER);
        for (int i = 0; i < ALPHA; i++) begin
            if (letter == letter_t'(i)) mapped = ROTOR_I_INV[i];
        end
    end

endmodule

// File: rtl/rotor_reverse.sv
// rotor_reverse: return-path (reflector-to-keyboard) stage for one Rotor I.
// Owns the rotor position counter and turnover carry, and runs letters
// through the inverse wiring in a 2-stage valid/ready pipeline.
//   clk, rst_n           clock, asynchronous active-low reset
//   pos_load, pos_init   load position (values >= 26 load 0)
//   ring_set             ring setting, sampled per letter at accept
//   step_in              advance position by one (load has priority)
//   carry_out            1-cycle pulse after a step taken from NOTCH
//   position             current rotor position
//   in_valid/in_ready/in_letter     letter from the reflector side
//   out_valid/out_ready/out_letter  letter toward the keyboard side
module rotor_reverse #(
    parameter int NOTCH = 16,
    parameter int ALPHA = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pos_load,
    input  logic [4:0] pos_init,
    input  logic [4:0] ring_set,
    input  logic       step_in,
    output logic       carry_out,
    output logic [4:0] position,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_letter,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_letter
);
    import enigma_pkg::*;

    localparam letter_t ALPHA_L = letter_t'(ALPHA);
    localparam letter_t LAST_L  = letter_t'(ALPHA - 1);
    localparam letter_t NOTCH_L = letter_t'(NOTCH);

    // ---------------------------------------------------------------
    // Position counter and turnover carry
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            position  <= '0;
            carry_out <= 1'b0;
        end else if (pos_load) begin
            // Load wins over a simultaneous step and never carries.
            position  <= (pos_init >= ALPHA_L) ? '0 : pos_init;
            carry_out <= 1'b0;
        end else if (step_in) begin
            position  <= (position == LAST_L) ? '0 : position + 5'd1;
            carry_out <= (position == NOTCH_L);
        end else begin
            carry_out <= 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------
    logic    s1_valid;
    letter_t s1_a;      // contact index entering the wiring
    letter_t s1_d;      // offset added back on the way out: (r - p) mod 26
    logic    s1_inv;    // input letter was out of range
    logic    s2_adv;
    logic    accept;

    always_comb begin
        s2_adv   = !out_valid || out_ready;
        in_ready = !s1_valid || s2_adv;
        accept   = in_valid && in_ready;
    end

    // ---------------------------------------------------------------
    // Stage 1: offset the incoming letter by position and ring.
    // position/ring_set are the register/input values of the accept
    // cycle, so a step on that same edge does not affect this letter.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_d     <= '0;
            s1_inv   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (accept) begin
                s1_a   <= mod26_add(in_letter, position, ring_set);
                s1_d   <= mod26_add(ring_set, '0, position);
                s1_inv <= (in_letter >= ALPHA_L);
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: inverse wiring, then undo the offset
    // ---------------------------------------------------------------
    letter_t wired;

    rotor_inv_lut u_lut (
        .letter (s1_a),
        .mapped (wired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_letter <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_letter <= s1_inv ? letter_t'(INVALID_LETTER)
                                     : mod26_add(wired, s1_d, '0);
            end
        end
    end

endmodule

// File: tb/tb_rotor_reverse.sv
// Bench for rotor_reverse: directed steps from the test plan followed by a
// randomized phase; a negedge monitor checks every output letter and the
// position/carry against a reference model built from the wiring string.
module tb_rotor_reverse;

    localparam int NOTCH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pos_load = 1'b0;
    logic [4:0] pos_init = '0;
    logic [4:0] ring_set = '0;
    logic       step_in = 1'b0;
    logic       carry_out;
    logic [4:0] position;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] in_letter = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] out_letter;

    rotor_reverse #(.NOTCH(NOTCH), .ALPHA(26)) dut (
        .clk(clk), .rst_n(rst_n),
        .pos_load(pos_load), .pos_init(pos_init), .ring_set(ring_set),
        .step_in(step_in), .carry_out(carry_out), .position(position),
        .in_valid(in_valid), .in_ready(in_ready), .in_letter(in_letter),
        .out_valid(out_valid), .out_ready(out_ready), .out_letter(out_letter)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int inv_wire(input int x);
        string w;
        w = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
        for (int j = 0; j < 26; j++)
            if (int'(w[j]) - 65 == x) return j;
        return -1;
    endfunction

    function automatic int model(input int in, input int p, input int r);
        int a;
        if (in >= 26) return 31;
        a = (in + p - r + 52) % 26;
        return (inv_wire(a) + r - p + 52) % 26;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int q[$];
    int exp_pos   = 0;
    int exp_carry = 0;
    bit stalled   = 0;
    int held      = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_pos   = 0;
            exp_carry = 0;
            stalled   = 0;
        end else begin
            chk("position", position, exp_pos);
            chk("carry_out", carry_out, exp_carry);
            if (stalled) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_letter", out_letter, held);
            end
            if (out_valid && out_ready) begin
                chk("out_expected", (q.size() > 0), 1);
                if (q.size() > 0) chk("out_letter", out_letter, q.pop_front());
            end
            stalled = out_valid && !out_ready;
            held    = out_letter;
            if (in_valid && in_ready)
                q.push_back(model(in_letter, exp_pos, ring_set));
            if (pos_load) begin
                exp_pos   = (pos_init >= 26) ? 0 : pos_init;
                exp_carry = 0;
            end else if (step_in) begin
                exp_carry = (exp_pos == NOTCH);
                exp_pos   = (exp_pos + 1) % 26;
            end else begin
                exp_carry = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pos(input int p);
        pos_load = 1'b1;
        pos_init = 5'(p);
        tick();
        pos_load = 1'b0;
    endtask

    // one letter through an idle pipe with out_ready high
    task automatic one_letter(input string tag, input int x, input int e);
        in_valid  = 1'b1;
        in_letter = 5'(x);
        tick();
        in_valid = 1'b0;
        chk({tag, "_early"}, out_valid, 0);
        tick();
        chk({tag, "_valid"}, out_valid, 1);
        chk(tag, out_letter, e);
        tick();
    endtask

    initial begin
        // ---- reset state ----
        #2;
        chk("rst_position", position, 0);
        chk("rst_carry", carry_out, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_letter", out_letter, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        tick();

        // ---- zero offsets, back-to-back ----
        in_valid = 1'b1; in_letter = 5'd4;
        tick();
        in_letter = 5'd0;
        chk("zo_lat1", out_valid, 0);
        tick();
        in_letter = 5'd9;
        chk("zo_v0", out_valid, 1);
        chk("zo_0", out_letter, 0);
        tick();
        in_valid = 1'b0;
        chk("zo_v1", out_valid, 1);
        chk("zo_1", out_letter, 20);
        tick();
        chk("zo_v2", out_valid, 1);
        chk("zo_2", out_letter, 25);
        tick();
        chk("zo_drain", out_valid, 0);

        // ---- position and ring offsets ----
        load_pos(1);
        one_letter("pos1", 0, 21);
        load_pos(25);
        one_letter("pos25", 0, 10);
        load_pos(0);
        ring_set = 5'd1;
        one_letter("ring1", 0, 10);
        load_pos(3);
        ring_set = 5'd3;
        one_letter("pos3ring3", 7, 15);
        ring_set = 5'd0;

        // ---- invalid letter ----
        one_letter("invalid", 27, 31);

        // ---- stepping and carry ----
        load_pos(15);
        step_in = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            chk("step_pos", position, (15 + i) % 26);
            chk("step_carry", carry_out, (i == 2) ? 1 : 0);
        end
        step_in = 1'b0;
        load_pos(16);
        pos_load = 1'b1; step_in = 1'b1; pos_init = 5'd16;
        tick();
        pos_load = 1'b0; step_in = 1'b0;
        chk("loadstep_pos", position, 16);
        chk("loadstep_carry", carry_out, 0);
        load_pos(30);
        chk("load_oob", position, 0);

        // ---- backpressure ----
        out_ready = 1'b0;
        in_valid = 1'b1; in_letter = 5'd2;
        #1 chk("bp_rdy0", in_ready, 1);
        tick();
        in_letter = 5'd11;
        chk("bp_rdy1", in_ready, 1);
        tick();
        in_letter = 5'd19;
        chk("bp_rdy2", in_ready, 0);
        tick();
        chk("bp_stuck", in_ready, 0);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_rel", in_ready, 1);
        tick();                       // third letter accepted here
        in_valid = 1'b0;
        chk("bp_o2", out_valid, 1);
        tick();
        chk("bp_o3", out_valid, 1);
        tick();
        chk("bp_empty", out_valid, 0);

        // ---- reset mid-flight ----
        load_pos(7);
        out_ready = 1'b0;
        in_valid = 1'b1; in_letter = 5'd3;
        tick();
        in_letter = 5'd5;
        tick();
        in_valid = 1'b0;
        chk("mid_pending", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_position", position, 0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_stale", out_valid, 0);
        end

        // ---- randomized traffic ----
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_letter = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(26, 31))
                                                    : 5'($urandom_range(0, 25));
            out_ready = ($urandom_range(0, 2) != 0);
            pos_load  = ($urandom_range(0, 15) == 0);
            pos_init  = 5'($urandom_range(0, 31));
            step_in   = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) ring_set = 5'($urandom_range(0, 25));
            tick();
        end
        in_valid = 1'b0; pos_load = 1'b0; step_in = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
